wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback arbiter and scoreboard in front of the register file write port.
//  Shares the single write port (sel_in/in_reg/in_flags/not_enable) between the ALU and load/store (MEM) result paths.
//  Tracks in-flight destination registers and flags so that issue stalls on RAW/WAW hazards.
//  Also diverts r15 (PC) results to the fetch unit.
// PARAMETERS
//  RR_ENABLE  1  1 = round-robin between ALU and MEM on contention; 0 = ALU always wins
//  DATA_W     32 result width
// PORTS
//  clock          in   1       system clock; all state updates on posedge
//  not_reset      in   1       asynchronous, active-low reset
//  issue_valid    in   1       decode presents an instruction this cycle
//  issue_src0/1   in   4       source registers read by the instruction
//  issue_dst      in   4       destination register
//  issue_wr_reg   in   1       instruction writes issue_dst
//  issue_rd_flags in   1       instruction consumes flags
//  issue_wr_flags in   1       instruction updates flags
//  issue_stall    out  1       hold decode; combinational from scoreboard
//  alu_valid      in   1       ALU result beat valid
//  alu_dst        in   4       ALU destination register
//  alu_wr_reg     in   1       beat writes alu_dst (0 = flags-only, e.g. CMP)
//  alu_data       in   DATA_W  ALU result
//  alu_set_flags  in   1       beat updates flags
//  alu_flags      in   4       new NZCV
//  alu_ready      out  1       ALU beat accepted this cycle
//  mem_valid      in   1       load result beat valid
//  mem_dst        in   4       load destination register
//  mem_data       in   DATA_W  load data
//  mem_ready      out  1       MEM beat accepted this cycle
//  cur_flags      in   4       register file out_flags; used to preserve flags on non-flag writes
//  rf_not_enable  out  1       to register file not_enable
//  rf_sel_in      out  4       to register file sel_in
//  rf_in_reg      out  DATA_W  to register file in_reg
//  rf_in_flags    out  4       to register file in_flags
//  pc_wr_valid    out  1       one-cycle pulse: r15 result for fetch
//  pc_wr_data     out  DATA_W  r15 value
// BEHAVIOUR
//  Reset (async, not_reset=0):
//   - rf_not_enable=1; rf_sel_in, rf_in_reg, rf_in_flags, pc_wr_*=0
//   - busy[14:0]=0, flags_busy=0, round-robin pointer=ALU
//   - A beat accepted before reset is dropped, with no register file write.
//  Handshake:
//   - valid/ready; a beat transfers at the posedge where valid&&ready.
//   - ready is combinational from the valid inputs and the pointer; held 0 while in reset.
//   - At most one grant per cycle; the loser keeps valid and data stable.
//  Contention, both valid:
//   - RR_ENABLE=1: grant the pointer side, then point to the other side.
//   - Single requester: always granted; pointer unchanged.
//  Commit, registered; accepted at posedge P, write cycle is P..P+1:
//   - rf_not_enable=0 for exactly that cycle; the register file writes at its negedge.
//   - Back-to-back accepts give consecutive low cycles, i.e. 1 commit/cycle.
//   - rf_sel_in = dst. Exceptions: ALU flags-only beats and every dst=15 use 4'hF, the register file discard slot, which leaves r0-r14 unchanged.
//   - rf_in_flags = alu_flags when alu_set_flags; otherwise cur_flags sampled at P. MEM beats always use cur_flags.
//   - dst=15 with wr_reg: pc_wr_valid=1 for the write cycle, pc_wr_data=data.
//  Scoreboard:
//   - Issue accepted when issue_valid && !issue_stall.
//     - Sets busy[issue_dst] if issue_wr_reg and dst!=15.
//     - Sets flags_busy if issue_wr_flags.
//   - Clear happens at posedge P+1, the end of the write cycle:
//     - busy[dst] clears for the committed dst.
//     - flags_busy clears when an ALU beat with set_flags is committed.
//   - Set and clear of the same bit in one cycle: set wins.
//   - issue_stall = issue_valid & ( busy[src0] | busy[src1] | (issue_wr_reg & busy[dst]) | (issue_rd_flags & flags_busy) ).
//   - busy index 15 reads as 0.
// TESTING
//  1 Pull not_reset low while rf_not_enable=0 -> rf_not_enable=1 asynchronously, busy=0; after release, no write occurs.
//  2 Issue dst=r3; next issue reads r3 -> issue_stall=1 until ALU commits r3=0x1234; stall drops at P+1; regfile r3=0x1234.
//  3 ALU(r1,0xAAAA) and MEM(r2,0x5555) valid together, RR=1 -> r1 committed, then r2 on the next cycle; next contention grants MEM first.
//  4 MEM write r4=0xDEAD with cur_flags=4'b1010 -> rf_sel_in=4, rf_in_flags=4'b1010.
//  5 ALU dst=15, data=0x100 -> pc_wr_valid pulses 1 cycle with 0x100; rf_sel_in=4'hF; r0-r14 unchanged.
//  6 Issue CMP (wr_flags), then an issue needing flags stalls; ALU flags-only beat with 4'b0100 -> rf_sel_in=4'hF, rf_in_flags=0100, stall clears at P+1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle between decode, the ALU/MEM result paths, the register file write port and fetch.
// The arbiter uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic [3:0]        issue_src0;
  logic [3:0]        issue_src1;
  logic [3:0]        issue_dst;
  logic              issue_wr_reg;
  logic              issue_rd_flags;
  logic              issue_wr_flags;
  logic              issue_stall;

  logic              alu_valid;
  logic [3:0]        alu_dst;
  logic              alu_wr_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_set_flags;
  logic [3:0]        alu_flags;
  logic              alu_ready;

  logic              mem_valid;
  logic [3:0]        mem_dst;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic [3:0]        cur_flags;
  logic              rf_not_enable;
  logic [3:0]        rf_sel_in;
  logic [DATA_W-1:0] rf_in_reg;
  logic [3:0]        rf_in_flags;
  logic              pc_wr_valid;
  logic [DATA_W-1:0] pc_wr_data;

  modport slave (
    input  issue_valid, issue_src0, issue_src1, issue_dst,
    input  issue_wr_reg, issue_rd_flags, issue_wr_flags,
    output issue_stall,
    input  alu_valid, alu_dst, alu_wr_reg, alu_data, alu_set_flags, alu_flags,
    output alu_ready,
    input  mem_valid, mem_dst, mem_data,
    output mem_ready,
    input  cur_flags,
    output rf_not_enable, rf_sel_in, rf_in_reg, rf_in_flags,
    output pc_wr_valid, pc_wr_data
  );

  modport master (
    output issue_valid, issue_src0, issue_src1, issue_dst,
    output issue_wr_reg, issue_rd_flags, issue_wr_flags,
    input  issue_stall,
    output alu_valid, alu_dst, alu_wr_reg, alu_data, alu_set_flags, alu_flags,
    input  alu_ready,
    output mem_valid, mem_dst, mem_data,
    input  mem_ready,
    output cur_flags,
    input  rf_not_enable, rf_sel_in, rf_in_reg, rf_in_flags,
    input  pc_wr_valid, pc_wr_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register file write port between ALU and MEM results,
// keeps a busy scoreboard for RAW/WAW issue stalls and diverts r15 results to fetch.
module wb_arbiter #(
  parameter int RR_ENABLE = 1,
  parameter int DATA_W    = 32
) (
  input logic           clock,
  input logic           not_reset,
  wb_arbiter_if.slave   bus
);

  typedef enum logic {PTR_ALU, PTR_MEM} ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic              alu_grant, mem_grant;

  logic              commit_q, commit_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        flags_q, flags_d;
  logic              pc_valid_q, pc_valid_d;
  logic [DATA_W-1:0] pc_data_q, pc_data_d;
  logic              clr_reg_q, clr_reg_d;
  logic              clr_flags_q, clr_flags_d;
  logic [3:0]        clr_idx_q, clr_idx_d;

  logic [14:0]       busy_q, busy_d;
  logic              flags_busy_q, flags_busy_d;
  logic [15:0]       busy_vec;
  logic [15:0]       busy_next;
  logic              issue_stall;
  logic              issue_accept;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      ptr_q        <= PTR_ALU;
      commit_q     <= 1'b0;
      sel_q        <= '0;
      data_q       <= '0;
      flags_q      <= '0;
      pc_valid_q   <= 1'b0;
      pc_data_q    <= '0;
      clr_reg_q    <= 1'b0;
      clr_flags_q  <= 1'b0;
      clr_idx_q    <= '0;
      busy_q       <= '0;
      flags_busy_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      commit_q     <= commit_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      flags_q      <= flags_d;
      pc_valid_q   <= pc_valid_d;
      pc_data_q    <= pc_data_d;
      clr_reg_q    <= clr_reg_d;
      clr_flags_q  <= clr_flags_d;
      clr_idx_q    <= clr_idx_d;
      busy_q       <= busy_d;
      flags_busy_q <= flags_busy_d;
    end
  end

  // Grants are gated by reset so nothing can be handed off while the port is held.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    ptr_d     = ptr_q;
    if (not_reset) begin
      if (bus.alu_valid && bus.mem_valid) begin
        if (RR_ENABLE != 0 && ptr_q == PTR_MEM) begin
          mem_grant = 1'b1;
          ptr_d     = PTR_ALU;
        end else begin
          alu_grant = 1'b1;
          if (RR_ENABLE != 0) ptr_d = PTR_MEM;
        end
      end else begin
        alu_grant = bus.alu_valid;
        mem_grant = bus.mem_valid;
      end
    end
  end

  always_comb begin
    commit_d    = 1'b0;
    sel_d       = sel_q;
    data_d      = data_q;
    flags_d     = flags_q;
    pc_valid_d  = 1'b0;
    pc_data_d   = '0;
    clr_reg_d   = 1'b0;
    clr_flags_d = 1'b0;
    clr_idx_d   = clr_idx_q;
    if (alu_grant) begin
      commit_d    = 1'b1;
      data_d      = bus.alu_data;
      flags_d     = bus.alu_set_flags ? bus.alu_flags : bus.cur_flags;
      sel_d       = (!bus.alu_wr_reg || bus.alu_dst == 4'hF) ? 4'hF : bus.alu_dst;
      pc_valid_d  = bus.alu_wr_reg && bus.alu_dst == 4'hF;
      pc_data_d   = pc_valid_d ? bus.alu_data : '0;
      clr_reg_d   = bus.alu_wr_reg && bus.alu_dst != 4'hF;
      clr_flags_d = bus.alu_set_flags;
      clr_idx_d   = bus.alu_dst;
    end else if (mem_grant) begin
      commit_d    = 1'b1;
      data_d      = bus.mem_data;
      flags_d     = bus.cur_flags;
      sel_d       = bus.mem_dst;
      pc_valid_d  = bus.mem_dst == 4'hF;
      pc_data_d   = pc_valid_d ? bus.mem_data : '0;
      clr_reg_d   = bus.mem_dst != 4'hF;
      clr_idx_d   = bus.mem_dst;
    end
  end

  // Clears from the finishing write cycle are applied before new issues so set wins.
  always_comb begin
    busy_vec     = {1'b0, busy_q};
    issue_stall  = bus.issue_valid & (busy_vec[bus.issue_src0] | busy_vec[bus.issue_src1] |
                   (bus.issue_wr_reg & busy_vec[bus.issue_dst]) |
                   (bus.issue_rd_flags & flags_busy_q));
    issue_accept = bus.issue_valid & ~issue_stall;
    busy_next    = busy_vec;
    flags_busy_d = flags_busy_q;
    if (clr_reg_q) busy_next[clr_idx_q] = 1'b0;
    if (clr_flags_q) flags_busy_d = 1'b0;
    if (issue_accept && bus.issue_wr_reg) busy_next[bus.issue_dst] = 1'b1;
    if (issue_accept && bus.issue_wr_flags) flags_busy_d = 1'b1;
    busy_d = busy_next[14:0];
  end

  assign bus.issue_stall   = issue_stall;
  assign bus.alu_ready     = alu_grant;
  assign bus.mem_ready     = mem_grant;
  assign bus.rf_not_enable = ~commit_q;
  assign bus.rf_sel_in     = sel_q;
  assign bus.rf_in_reg     = data_q;
  assign bus.rf_in_flags   = flags_q;
  assign bus.pc_wr_valid   = pc_valid_q;
  assign bus.pc_wr_data    = pc_data_q;

endmodule
